// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: walks every input combination of a small N_IN-input,
// 1-output combinational block, captures its outputs into a truth table and
// compares that table against an expected mask.
//
// Optional feature (macro): TT_STOP_ON_FAIL_EN
//   defined   - end the sweep at the first vector whose output differs from expected
//   undefined - always sweep all W vectors, then compare the whole table
//
// Ports:
//   clk             rising-edge clock
//   rst_n           synchronous active-low reset
//   start_i         begin a sweep (accepted in IDLE or DONE only)
//   expected_i      expected table, bit i = output for input i (latched on start)
//   dut_in_o        registered vector driven to the datapath
//   dut_out_i       datapath output
//   busy_o          high from start accept until DONE entry
//   done_o          level, high while in DONE
//   pass_o          captured table equals latched expected (valid with done_o)
//   truth_table_o   captured outputs, bit i = output sampled for vector i
//   mismatch_idx_o  lowest differing index when done_o && !pass_o, else 0
module truth_table_sweeper #(
    parameter int unsigned N_IN          = 3,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start_i,
    input  logic [(1<<N_IN)-1:0]    expected_i,
    output logic [N_IN-1:0]         dut_in_o,
    input  logic                    dut_out_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    pass_o,
    output logic [(1<<N_IN)-1:0]    truth_table_o,
    output logic [N_IN-1:0]         mismatch_idx_o
);

    localparam int unsigned W     = 1 << N_IN;
    localparam int unsigned CNT_W = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
    localparam logic [N_IN-1:0] LAST_IDX = N_IN'(W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_APPLY,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [N_IN-1:0]   idx_q, idx_d;
    logic [N_IN-1:0]   dut_in_q, dut_in_d;
    logic [W-1:0]      exp_q, exp_d;
    logic [W-1:0]      table_q, table_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic [N_IN-1:0]   mis_q, mis_d;

    // Table including the bit being sampled this cycle, and its lowest diff index
    logic [W-1:0]      table_new;
    logic [W-1:0]      diff;
    logic [N_IN-1:0]   first_diff;
    logic              fail_stop;

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            dut_in_q <= '0;
            exp_q    <= '0;
            table_q  <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            mis_q    <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            dut_in_q <= dut_in_d;
            exp_q    <= exp_d;
            table_q  <= table_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
            mis_q    <= mis_d;
        end
    end

    // Next-state and output logic
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        dut_in_d = dut_in_q;
        exp_d    = exp_q;
        table_d  = table_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = done_q;
        pass_d   = pass_q;
        mis_d    = mis_q;

        table_new        = table_q;
        table_new[idx_q] = dut_out_i;
        diff             = table_new ^ exp_q;
        first_diff       = '0;
        // Scan downwards so the lowest set bit wins
        for (int i = int'(W) - 1; i >= 0; i--) begin
            if (diff[i]) first_diff = N_IN'(i);
        end

`ifdef TT_STOP_ON_FAIL_EN
        fail_stop = (dut_out_i != exp_q[idx_q]);
`else
        fail_stop = 1'b0;
`endif

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    state_d  = S_APPLY;
                    exp_d    = expected_i;
                    table_d  = '0;
                    idx_d    = '0;
                    dut_in_d = '0;
                    busy_d   = 1'b1;
                    done_d   = 1'b0;
                    pass_d   = 1'b0;
                    mis_d    = '0;
                end
            end
            S_APPLY: begin
                cnt_d   = CNT_W'(SETTLE_CYCLES);
                state_d = (SETTLE_CYCLES == 0) ? S_SAMPLE : S_SETTLE;
            end
            S_SETTLE: begin
                // Counter holds remaining settle cycles including this one
                if (cnt_q <= CNT_W'(1)) begin
                    cnt_d   = '0;
                    state_d = S_SAMPLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_SAMPLE: begin
                table_d = table_new;
                if (fail_stop) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = 1'b0;
                    mis_d   = idx_q;
                end else if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (diff == '0);
                    mis_d   = (diff == '0) ? '0 : first_diff;
                end else begin
                    idx_d    = idx_q + N_IN'(1);
                    dut_in_d = idx_q + N_IN'(1);
                    state_d  = S_APPLY;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign dut_in_o       = dut_in_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign pass_o         = pass_q;
    assign truth_table_o  = table_q;
    assign mismatch_idx_o = mis_q;

endmodule
